// File: rtl/seq_div_16by8.sv
// Sequential restoring divider: 2*W-bit dividend by W-bit divisor, one
// quotient bit per clock behind valid/ready handshakes on both sides.
module seq_div_16by8 #(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           div_by_zero,
  output logic           overflow
);

  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  // Partial remainder; always below the divisor between steps, so W bits hold it.
  logic [W-1:0]  rem_q;
  // Low dividend half shifts out MSB-first while quotient bits shift in at the LSB.
  logic [W-1:0]  shift_q;
  logic [W-1:0]  dvs_q;
  logic [CW-1:0] count;

  logic [W:0]    r_shift;
  logic [W-1:0]  r_diff;
  logic          q_bit;
  logic [W-1:0]  r_next;

  // One restoring step: shift in the next dividend bit, compare W+1 wide, subtract.
  always_comb begin
    r_shift = {rem_q, shift_q[W-1]};
    r_diff  = r_shift[W-1:0] - dvs_q;
    q_bit   = (r_shift >= {1'b0, dvs_q});
    r_next  = q_bit ? r_diff : r_shift[W-1:0];
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      rem_q       <= '0;
      shift_q     <= '0;
      dvs_q       <= '0;
      count       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            dvs_q    <= divisor;
            shift_q  <= dividend[W-1:0];
            if (divisor == '0) begin
              state       <= DONE;
              out_valid   <= 1'b1;
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
              quotient    <= '1;
              remainder   <= '0;
            end else if (dividend[2*W-1:W] >= divisor) begin
              state       <= DONE;
              out_valid   <= 1'b1;
              div_by_zero <= 1'b0;
              overflow    <= 1'b1;
              quotient    <= '1;
              remainder   <= '0;
            end else begin
              state <= CALC;
              rem_q <= dividend[2*W-1:W];
              count <= '0;
            end
          end
        end

        CALC: begin
          rem_q   <= r_next;
          shift_q <= {shift_q[W-2:0], q_bit};
          count   <= count + CW'(1);
          if (count == CW'(W - 1)) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            quotient    <= {shift_q[W-2:0], q_bit};
            remainder   <= r_next;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end
        end

        DONE: begin
          if (out_valid && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div_16by8.sv
// Self-checking bench for seq_div_16by8: directed corner cases then random
// operations against an arithmetic reference model.
module tb_seq_div_16by8;

  localparam int unsigned W   = 8;
  localparam int unsigned MAXQ = (1 << W) - 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           div_by_zero;
  logic           overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_div_16by8 #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer division; overflow when the true quotient exceeds W bits.
  task automatic model(input int unsigned dvd, input int unsigned dvs,
                       output int unsigned q, output int unsigned r,
                       output bit dz, output bit ov);
    dz = (dvs == 0);
    ov = 1'b0;
    if (dz) begin
      q = MAXQ; r = 0;
    end else if (dvd / dvs > MAXQ) begin
      ov = 1'b1; q = MAXQ; r = 0;
    end else begin
      q = dvd / dvs; r = dvd % dvs;
    end
  endtask

  task automatic check_result(input string tag, input int unsigned q, input int unsigned r,
                              input bit dz, input bit ov);
    chk({tag, "_quot"}, 32'(quotient), 32'(q));
    chk({tag, "_rem"},  32'(remainder), 32'(r));
    chk({tag, "_dz"},   32'(div_by_zero), 32'(dz));
    chk({tag, "_ov"},   32'(overflow), 32'(ov));
  endtask

  // Full operation: accept, measure latency, hold result for `hold` cycles, then drain.
  task automatic run_op(input string tag, input int unsigned dvd, input int unsigned dvs,
                        input int unsigned hold, input bit poke);
    int unsigned q, r;
    bit dz, ov;
    int edges;
    model(dvd, dvs, q, r, dz, ov);
    dividend  = 16'(dvd);
    divisor   = 8'(dvs);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    chk({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    edges = 0;
    while (!out_valid && edges < 20) begin
      step();
      edges++;
    end
    // Error results are registered on the accept edge itself.
    chk({tag, "_latency"}, 32'(edges), (dz || ov) ? 32'd0 : 32'(W));
    check_result(tag, q, r, dz, ov);
    chk({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
    for (int i = 0; i < int'(hold); i++) begin
      if (poke) begin
        in_valid = i[0];
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
      end
      step();
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      check_result({tag, "_hold"}, q, r, dz, ov);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_drain_in_ready"}, 32'(in_ready), 32'd1);
    check_result({tag, "_after"}, q, r, dz, ov);
  endtask

  initial begin
    int unsigned rd, rs, rq;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) step();
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    check_result("reset", 0, 0, 1'b0, 1'b0);
    rst = 1'b0;
    step();

    run_op("t1_1000_7", 1000, 7, 0, 1'b0);
    run_op("t2_fe00_255", 16'hFE00, 255, 1, 1'b0);
    run_op("t3_div0", 16'h1234, 0, 0, 1'b0);
    run_op("t4_ovf", 16'h0800, 8, 0, 1'b0);
    run_op("t4_07ff_8", 16'h07FF, 8, 0, 1'b0);
    run_op("t5_hold", 50000, 200, 5, 1'b1);
    run_op("t5_next", 12345, 99, 0, 1'b0);

    // Reset in the 4th CALC cycle aborts the operation.
    dividend = 16'd1000;
    divisor  = 8'd7;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_out_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_in_ready", 32'(in_ready), 32'd1);
    check_result("t6_rst", 0, 0, 1'b0, 1'b0);
    repeat (10) step();
    chk("t6_no_output", 32'(out_valid), 32'd0);
    run_op("t6_100_3", 100, 3, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      rs = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, MAXQ);
      if (rs != 0 && $urandom_range(0, 3) != 0) begin
        rq = $urandom_range(0, MAXQ);
        rd = rq * rs + $urandom_range(0, rs - 1);
      end else begin
        rd = $urandom_range(0, 65535);
      end
      run_op("rand", rd, rs, $urandom_range(0, 2), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
